cache_trace_sequencer: RTL and testbench
========================================

Name: cache_trace_sequencer

Overview:
- Upstream stage of the cache top.
- Accepts memory-trace requests (48-bit address plus ASCII op byte) over a valid/ready push interface, and buffers them in a small FIFO.
- Issues them to the cache engine's cache_addr/cache_op inputs, one request per issue slot, with a programmable gap between issues.
- Normalises and filters op codes, and keeps issue/drop statistics for the testbench.

Parameters:
- ADDR_W, 48, request address width; matches the cache_addr width.
- OP_W, 8, op byte width; matches the cache_op width.
- DEPTH, 8, FIFO entries; power of two, ≥2.
- ISSUE_GAP, 2, cycles from one issue to the next (≥1; 1 = back-to-back).

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- reset, input, 1, asynchronous active-low reset (0 = reset asserted).
- enable, input, 1, 1 = issue from FIFO allowed; 0 = hold (pushes still accepted).
- flush, input, 1, synchronous FIFO clear; counters unaffected.
- in_valid, input, 1, trace request present.
- in_ready, output, 1, FIFO can accept (= !full).
- in_addr, input, ADDR_W, request address.
- in_op, input, OP_W, ASCII op: 'R'/'r' = read, 'W'/'w' = write.
- cache_addr, output, ADDR_W, address to cache engine.
- cache_op, output, OP_W, 8'h52 read, 8'h57 write, 8'h00 no-op.
- issue_valid, output, 1, 1 in the cycle cache_addr/cache_op carry a real request.
- fifo_count, output, $clog2(DEPTH)+1, current occupancy.
- issued_count, output, 18, requests issued; saturates at 18'h3FFFF.
- dropped_count, output, 16, pushes rejected for illegal op; saturates at 16'hFFFF.
- idle, output, 1, 1 when state is S_IDLE and the FIFO is empty.

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: cache_addr=0, cache_op=8'h00, issue_valid=0, fifo_count=0, issued_count=0, dropped_count=0.
  - Internal state: state=S_IDLE, gap counter=0, FIFO pointers=0.
  - Reset release is sampled synchronously; the first push is possible the cycle after deassertion.
- Push:
  - A push occurs when in_valid && in_ready at a clock edge.
  - Op normalisation: 'r' maps to 8'h52 and 'w' maps to 8'h57.
  - Any other op byte is accepted (handshake completes) but not stored, and dropped_count increments.
  - in_ready is purely !full; there is no combinational path from pop to in_ready.
- Pop and push in the same cycle: fifo_count is unchanged; the FIFO holds a correct ordering.
- Issue outputs are registered. cache_addr/cache_op/issue_valid are updated on the edge where the FSM leaves S_IDLE or S_GAP toward S_ISSUE.
- FSM:
  - S_IDLE:
    - Outputs: cache_op=8'h00, issue_valid=0.
    - If enable && !empty && !flush: pop the head and load cache_addr/cache_op; issue_valid=1 next cycle → S_ISSUE.
  - S_ISSUE (exactly 1 cycle, request visible to the engine):
    - Increment issued_count (saturating).
    - If ISSUE_GAP==1 && enable && !empty: pop the next entry immediately and stay in S_ISSUE (back-to-back).
    - Else if ISSUE_GAP>1: load gap counter with ISSUE_GAP-2 → S_GAP.
    - Else → S_IDLE.
  - S_GAP:
    - Outputs: cache_op=8'h00, issue_valid=0; cache_addr holds its last value.
    - Decrement the gap counter; at 0 behave as S_IDLE (may pop directly → S_ISSUE).
    - Result: issue spacing is exactly ISSUE_GAP cycles.
- enable=0:
  - An in-flight S_ISSUE cycle still completes.
  - No new pop occurs; the gap still counts down.
- flush=1:
  - FIFO pointers and count go to 0 the next edge.
  - A push in the same cycle is discarded and does not increment dropped_count.
  - An in-flight S_ISSUE is not cancelled; no pop occurs that cycle.
- Pointers wrap modulo DEPTH; full when count==DEPTH, empty when count==0.
- Mid-operation reset: everything returns to reset values immediately; FIFO contents become don't-care.

Decomposition:
- Shared package cache_pkg:
  - OP_READ=8'h52, OP_WRITE=8'h57, OP_NOP=8'h00, OP_READ_LC=8'h72, OP_WRITE_LC=8'h77.
  - seq_state_t enum {S_IDLE, S_ISSUE, S_GAP}.
  - Request struct {addr[47:0], op[7:0]}.
- One sub-module: cache_req_fifo.
  - Synchronous FIFO with parameter DEPTH.
  - Ports: push, pop, flush, din, dout, full, empty, count.
  - Async active-low reset.
- The sequencer contains the op filter, FSM, gap counter and statistics counters.

Test Plan:
- Reset, then push 3 reads (0x1000, 0x2000, 0x3000, op 'R') with enable=1, ISSUE_GAP=2 → issue_valid pulses every 2nd cycle; cache_op=8'h52 with addresses in order; issued_count=3; idle=1 afterwards.
- Push 'w' at 0xABC, then op 'X' at 0xDEF → one issue with cache_op=8'h57, cache_addr=0xABC; dropped_count=1; 0xDEF never issued.
- enable=0, push 8 entries (DEPTH=8) → in_ready=0, fifo_count=8; a 9th in_valid is not accepted. Raise enable → 8 issues; in_ready returns to 1 the cycle after the first pop.
- ISSUE_GAP=1, FIFO holding 4 entries, enable=1 → issue_valid high for 4 consecutive cycles, then cache_op=8'h00.
- 5 entries queued, assert flush for 1 cycle during S_GAP → the in-flight issue completes, fifo_count=0 next cycle, no further issues; counters unchanged.
- Assert reset=0 mid-stream while issue_valid=1 → all outputs read 0 within the same cycle (asynchronous); after release, the first new push issues normally.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared op codes, sequencer states and request layout for the cache trace front end.
package cache_pkg;

    localparam logic [7:0] OP_READ     = 8'h52;
    localparam logic [7:0] OP_WRITE    = 8'h57;
    localparam logic [7:0] OP_NOP      = 8'h00;
    localparam logic [7:0] OP_READ_LC  = 8'h72;
    localparam logic [7:0] OP_WRITE_LC = 8'h77;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_GAP
    } seq_state_t;

    typedef struct packed {
        logic [47:0] addr;
        logic [7:0]  op;
    } cache_req_t;

    // Folds lower-case ops onto upper case; anything unrecognised comes back as OP_NOP.
    function automatic logic [7:0] normalise_op(input logic [7:0] op);
        logic [7:0] res;
        res = OP_NOP;
        case (op)
            OP_READ,  OP_READ_LC:  res = OP_READ;
            OP_WRITE, OP_WRITE_LC: res = OP_WRITE;
            default:               res = OP_NOP;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/cache_req_fifo.sv
// Small synchronous request FIFO with synchronous flush and occupancy count.
module cache_req_fifo #(
    parameter int W     = 56,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    // Storage is deliberately not reset; contents are only meaningful below count.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/cache_trace_sequencer.sv
// Trace request sequencer: filters and normalises ops, queues them, and issues one
// request per slot to the cache engine with a fixed spacing of ISSUE_GAP cycles.
//
// state   | meaning
// S_IDLE  | nothing in flight; pops as soon as enabled and the FIFO has work
// S_ISSUE | request on cache_addr/cache_op for exactly one cycle
// S_GAP   | spacing wait after an issue; behaves as S_IDLE once the counter hits 0
module cache_trace_sequencer
    import cache_pkg::*;
#(
    parameter int ADDR_W    = 48,
    parameter int OP_W      = 8,
    parameter int DEPTH     = 8,
    parameter int ISSUE_GAP = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_W-1:0]          in_addr,
    input  logic [OP_W-1:0]            in_op,
    output logic [ADDR_W-1:0]          cache_addr,
    output logic [OP_W-1:0]            cache_op,
    output logic                       issue_valid,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [17:0]                issued_count,
    output logic [15:0]                dropped_count,
    output logic                       idle
);

    localparam int RW = ADDR_W + OP_W;
    localparam int GW = (ISSUE_GAP > 2) ? $clog2(ISSUE_GAP - 1) : 1;
    localparam logic [GW-1:0] GAP_LOAD = (ISSUE_GAP > 1) ? GW'(ISSUE_GAP - 2) : '0;

    seq_state_t      state;
    logic [GW-1:0]   gap_cnt;
    logic [OP_W-1:0] norm_op;
    logic            op_legal;
    logic            accept;
    logic            fifo_push;
    logic            fifo_full;
    logic            fifo_empty;
    logic [RW-1:0]   fifo_dout;
    logic            slot_open;
    logic            pop_now;

    assign norm_op   = normalise_op(in_op);
    assign op_legal  = (norm_op != OP_NOP);
    assign in_ready  = !fifo_full;
    // A push that coincides with flush is swallowed entirely, legal or not.
    assign accept    = in_valid && in_ready && !flush;
    assign fifo_push = accept && op_legal;

    always_comb begin
        slot_open = 1'b0;
        case (state)
            S_IDLE:  slot_open = 1'b1;
            S_ISSUE: slot_open = (ISSUE_GAP == 1);
            S_GAP:   slot_open = (gap_cnt == '0);
            default: slot_open = 1'b0;
        endcase
    end

    assign pop_now = slot_open && enable && !fifo_empty && !flush;
    assign idle    = (state == S_IDLE) && fifo_empty;

    cache_req_fifo #(
        .W     (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (pop_now),
        .flush (flush),
        .din   ({in_addr, norm_op}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            gap_cnt      <= '0;
            cache_addr   <= '0;
            cache_op     <= OP_NOP;
            issue_valid  <= 1'b0;
            issued_count <= '0;
        end else begin
            if (state == S_ISSUE && issued_count != '1) issued_count <= issued_count + 18'd1;

            if (pop_now) begin
                cache_addr  <= fifo_dout[RW-1:OP_W];
                cache_op    <= fifo_dout[OP_W-1:0];
                issue_valid <= 1'b1;
                state       <= S_ISSUE;
            end else begin
                cache_op    <= OP_NOP;
                issue_valid <= 1'b0;
                case (state)
                    S_IDLE: state <= S_IDLE;
                    S_ISSUE: begin
                        if (ISSUE_GAP > 1) begin
                            gap_cnt <= GAP_LOAD;
                            state   <= S_GAP;
                        end else begin
                            state   <= S_IDLE;
                        end
                    end
                    S_GAP: begin
                        if (gap_cnt == '0) state <= S_IDLE;
                        else               gap_cnt <= gap_cnt - GW'(1);
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dropped_count <= '0;
        end else if (accept && !op_legal && dropped_count != '1) begin
            dropped_count <= dropped_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_cache_trace_sequencer.sv
// Bench for cache_trace_sequencer: two instances (gap 2 and gap 1) share stimulus and are
// checked every cycle against a queue-based timing model, plus literal expectations.
module tb_cache_trace_sequencer;

    logic        clk      = 1'b0;
    logic        reset    = 1'b0;
    logic        enable   = 1'b0;
    logic        flush    = 1'b0;
    logic        in_valid = 1'b0;
    logic [47:0] in_addr  = '0;
    logic [7:0]  in_op    = '0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [47:0] log0_addr[$];
    logic [7:0]  log0_op[$];
    int          log0_cyc[$];
    logic [47:0] log1_addr[$];
    int          log1_cyc[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : gi
        localparam int GAP = (g == 0) ? 2 : 1;

        logic        in_ready;
        logic [47:0] cache_addr;
        logic [7:0]  cache_op;
        logic        issue_valid;
        logic [3:0]  fifo_count;
        logic [17:0] issued_count;
        logic [15:0] dropped_count;
        logic        idle;

        cache_trace_sequencer #(
            .ADDR_W    (48),
            .OP_W      (8),
            .DEPTH     (8),
            .ISSUE_GAP (GAP)
        ) dut (
            .clk           (clk),
            .reset         (reset),
            .enable        (enable),
            .flush         (flush),
            .in_valid      (in_valid),
            .in_ready      (in_ready),
            .in_addr       (in_addr),
            .in_op         (in_op),
            .cache_addr    (cache_addr),
            .cache_op      (cache_op),
            .issue_valid   (issue_valid),
            .fifo_count    (fifo_count),
            .issued_count  (issued_count),
            .dropped_count (dropped_count),
            .idle          (idle)
        );

        // Model: a queue of stored requests, and the rule that pops are at least GAP edges apart.
        logic [55:0] q[$];
        logic        m_valid   = 1'b0;
        logic [47:0] m_addr    = '0;
        logic [7:0]  m_op      = '0;
        int          m_since   = 1000;
        int          m_issued  = 0;
        int          m_dropped = 0;
        int          m_count   = 0;
        logic        m_ready   = 1'b1;
        logic        m_idle    = 1'b1;
        logic        m_pop;
        logic        m_rdy;

        always @(posedge clk or negedge reset) begin
            if (!reset) begin
                q.delete();
                m_valid   = 1'b0;
                m_addr    = '0;
                m_op      = '0;
                m_since   = 1000;
                m_issued  = 0;
                m_dropped = 0;
            end else begin
                m_rdy = (q.size() < 8);
                m_pop = enable && !flush && (q.size() != 0) && (m_since >= GAP);
                if (m_valid && m_issued < 'h3FFFF) m_issued++;
                if (m_pop) begin
                    m_valid = 1'b1;
                    m_addr  = q[0][55:8];
                    m_op    = q[0][7:0];
                    void'(q.pop_front());
                    m_since = 1;
                end else begin
                    m_valid = 1'b0;
                    m_op    = 8'h00;
                    if (m_since < 1000) m_since++;
                end
                if (flush) begin
                    q.delete();
                end else if (in_valid && m_rdy) begin
                    if (in_op == 8'h52 || in_op == 8'h72)      q.push_back({in_addr, 8'h52});
                    else if (in_op == 8'h57 || in_op == 8'h77) q.push_back({in_addr, 8'h57});
                    else if (m_dropped < 'hFFFF)               m_dropped++;
                end
            end
            m_count = q.size();
            m_ready = (m_count < 8);
            m_idle  = !m_valid && (m_since > GAP) && (m_count == 0);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic compare_all();
        chk("u0_in_ready",  64'(gi[0].in_ready),      64'(gi[0].m_ready));
        chk("u0_addr",      64'(gi[0].cache_addr),    64'(gi[0].m_addr));
        chk("u0_op",        64'(gi[0].cache_op),      64'(gi[0].m_op));
        chk("u0_valid",     64'(gi[0].issue_valid),   64'(gi[0].m_valid));
        chk("u0_count",     64'(gi[0].fifo_count),    64'(gi[0].m_count));
        chk("u0_issued",    64'(gi[0].issued_count),  64'(gi[0].m_issued));
        chk("u0_dropped",   64'(gi[0].dropped_count), 64'(gi[0].m_dropped));
        chk("u0_idle",      64'(gi[0].idle),          64'(gi[0].m_idle));
        chk("u1_in_ready",  64'(gi[1].in_ready),      64'(gi[1].m_ready));
        chk("u1_addr",      64'(gi[1].cache_addr),    64'(gi[1].m_addr));
        chk("u1_op",        64'(gi[1].cache_op),      64'(gi[1].m_op));
        chk("u1_valid",     64'(gi[1].issue_valid),   64'(gi[1].m_valid));
        chk("u1_count",     64'(gi[1].fifo_count),    64'(gi[1].m_count));
        chk("u1_issued",    64'(gi[1].issued_count),  64'(gi[1].m_issued));
        chk("u1_dropped",   64'(gi[1].dropped_count), 64'(gi[1].m_dropped));
        chk("u1_idle",      64'(gi[1].idle),          64'(gi[1].m_idle));
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (gi[0].issue_valid) begin
            log0_addr.push_back(gi[0].cache_addr);
            log0_op.push_back(gi[0].cache_op);
            log0_cyc.push_back(cyc);
        end
        if (gi[1].issue_valid) begin
            log1_addr.push_back(gi[1].cache_addr);
            log1_cyc.push_back(cyc);
        end
        compare_all();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [47:0] a, input logic [7:0] op);
        in_valid = 1'b1;
        in_addr  = a;
        in_op    = op;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (!(gi[0].idle && gi[1].idle) && n < 60) begin
            step();
            n++;
        end
        chk({tag, "_idle_reached"}, 64'(gi[0].idle && gi[1].idle), 64'd1);
    endtask

    task automatic clear_logs();
        log0_addr.delete();
        log0_op.delete();
        log0_cyc.delete();
        log1_addr.delete();
        log1_cyc.delete();
    endtask

    initial begin
        int n;

        step();
        step();
        chk("rst_op",      64'(gi[0].cache_op),     64'h00);
        chk("rst_valid",   64'(gi[0].issue_valid),  64'd0);
        chk("rst_count",   64'(gi[0].fifo_count),   64'd0);
        chk("rst_idle",    64'(gi[0].idle),         64'd1);
        reset = 1'b1;
        step();

        // Three reads, gap 2 on instance 0
        enable = 1'b1;
        push(48'h1000, "R");
        push(48'h2000, "R");
        push(48'h3000, "R");
        wait_idle("t1");
        chk("t1_n_issues", 64'(log0_addr.size()), 64'd3);
        if (log0_addr.size() == 3) begin
            chk("t1_addr0", 64'(log0_addr[0]), 64'h1000);
            chk("t1_addr1", 64'(log0_addr[1]), 64'h2000);
            chk("t1_addr2", 64'(log0_addr[2]), 64'h3000);
            chk("t1_op0",   64'(log0_op[0]),   64'h52);
            for (int i = 1; i < 3; i++) chk("t1_spacing", 64'(log0_cyc[i] - log0_cyc[i-1]), 64'd2);
        end
        chk("t1_issued", 64'(gi[0].issued_count), 64'd3);
        chk("t1_idle",   64'(gi[0].idle),         64'd1);

        // Lower-case write is normalised; illegal op is dropped
        clear_logs();
        push(48'hABC, "w");
        push(48'hDEF, "X");
        wait_idle("t2");
        chk("t2_n_issues", 64'(log0_addr.size()), 64'd1);
        if (log0_addr.size() == 1) begin
            chk("t2_addr", 64'(log0_addr[0]), 64'hABC);
            chk("t2_op",   64'(log0_op[0]),   64'h57);
        end
        chk("t2_dropped", 64'(gi[0].dropped_count), 64'd1);

        // Fill with enable low, then drain
        enable = 1'b0;
        for (int i = 0; i < 8; i++) push(48'h100 + 48'(i), (i % 2 == 0) ? 8'h52 : 8'h57);
        chk("t3_full_ready", 64'(gi[0].in_ready),   64'd0);
        chk("t3_full_count", 64'(gi[0].fifo_count), 64'd8);
        push(48'h999, "R");
        chk("t3_ninth_count", 64'(gi[0].fifo_count),    64'd8);
        chk("t3_ninth_drop",  64'(gi[0].dropped_count), 64'd1);
        clear_logs();
        enable = 1'b1;
        step();
        chk("t3_ready_after_pop", 64'(gi[0].in_ready), 64'd1);
        wait_idle("t3");
        chk("t3_n_issues", 64'(log0_addr.size()), 64'd8);
        if (log0_addr.size() == 8)
            for (int i = 0; i < 8; i++) chk("t3_order", 64'(log0_addr[i]), 64'h100 + 64'(i));
        chk("t3_issued", 64'(gi[0].issued_count), 64'd12);

        // Back-to-back issue on the gap-1 instance
        enable = 1'b0;
        for (int i = 0; i < 4; i++) push(48'h400 + 48'(i), "r");
        clear_logs();
        enable = 1'b1;
        wait_idle("t4");
        chk("t4_n_issues", 64'(log1_addr.size()), 64'd4);
        if (log1_addr.size() == 4)
            for (int i = 1; i < 4; i++) chk("t4_consecutive", 64'(log1_cyc[i] - log1_cyc[i-1]), 64'd1);
        chk("t4_op_after", 64'(gi[1].cache_op),     64'h00);
        chk("t4_issued1",  64'(gi[1].issued_count), 64'd16);

        // Flush during the gap; a push in the flush cycle is discarded silently
        enable = 1'b0;
        for (int i = 0; i < 5; i++) push(48'h500 + 48'(i), "R");
        clear_logs();
        enable = 1'b1;
        step();
        step();
        chk("t5_in_gap", 64'(gi[0].issue_valid), 64'd0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_addr  = 48'hBAD;
        in_op    = "X";
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("t5_count0", 64'(gi[0].fifo_count), 64'd0);
        chk("t5_count1", 64'(gi[1].fifo_count), 64'd0);
        repeat (8) step();
        chk("t5_issues0",  64'(log0_addr.size()),    64'd1);
        chk("t5_issues1",  64'(log1_addr.size()),    64'd2);
        chk("t5_issued0",  64'(gi[0].issued_count),  64'd17);
        chk("t5_issued1",  64'(gi[1].issued_count),  64'd18);
        chk("t5_dropped",  64'(gi[0].dropped_count), 64'd1);

        // Asynchronous reset mid-issue
        push(48'h6000, "R");
        push(48'h6100, "W");
        n = 0;
        while (!gi[0].issue_valid && n < 20) begin
            step();
            n++;
        end
        chk("t6_reach_issue", 64'(gi[0].issue_valid), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_async_valid",   64'(gi[0].issue_valid),   64'd0);
        chk("t6_async_op",      64'(gi[0].cache_op),      64'h00);
        chk("t6_async_addr",    64'(gi[0].cache_addr),    64'd0);
        chk("t6_async_count",   64'(gi[0].fifo_count),    64'd0);
        chk("t6_async_issued",  64'(gi[0].issued_count),  64'd0);
        chk("t6_async_dropped", 64'(gi[0].dropped_count), 64'd0);
        step();
        step();
        reset = 1'b1;
        clear_logs();
        push(48'h7000, "R");
        wait_idle("t6");
        chk("t6_n_issues", 64'(log0_addr.size()), 64'd1);
        if (log0_addr.size() == 1) chk("t6_addr", 64'(log0_addr[0]), 64'h7000);
        chk("t6_issued", 64'(gi[0].issued_count), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
